// File: rtl/montgomery_mult.sv
// montgomery_mult: radix-2 bit-serial Montgomery multiplier, result = A*B*2^-N mod M.
// One operand bit of A is consumed per LOOP cycle; a single conditional subtract finishes.
module montgomery_mult #(
   parameter int N = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [N-1:0] in_m,
   output logic [N-1:0] result,
   output logic         busy,
   output logic         done
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, LOOP, SUB} state_t;
   state_t state;
   logic [N-1:0] a, b, m;
   logic [N+1:0] c, t1, t2, diff;
   logic [IW-1:0] i;
   // N+2 bits keep C + B + M exact even for out-of-contract operands
   always_comb begin
      t1 = c + (a[i] ? {2'b00, b} : '0);
      t2 = t1 + (t1[0] ? {2'b00, m} : '0);
      diff = c - {2'b00, m};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         result <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         c <= '0;
         i <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a <= in_a;
               b <= in_b;
               m <= in_m;
               c <= '0;
               i <= '0;
               busy <= 1'b1;
               state <= LOOP;
            end
            LOOP: begin
               c <= t2 >> 1;
               i <= i + 1'b1;
               state <= (i == IW'(N - 1)) ? SUB : LOOP;
            end
            SUB: begin
               result <= (c >= {2'b00, m}) ? diff[N-1:0] : c[N-1:0];
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_montgomery_mult.sv
// tb_montgomery_mult: directed checks on an N=4 instance plus random 1024-bit vectors
// checked against a shift-and-add modular reference.
module tb_montgomery_mult;
   localparam int NS = 4;
   localparam int NB = 1024;
   logic clk = 1'b0;
   logic reset, start_s, start_b;
   logic [NS-1:0] a_s, b_s, m_s, res_s;
   logic [NB-1:0] a_b, b_b, m_b, res_b;
   logic busy_s, done_s, busy_b, done_b;
   int nvec = 0, nerr = 0;
   int n, lat, cnt_busy, cnt_done;
   logic [NS-1:0] held;
   logic [NB-1:0] r2n;

   always #5 clk = ~clk;

   montgomery_mult #(.N(NS)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .in_a(a_s), .in_b(b_s), .in_m(m_s),
      .result(res_s), .busy(busy_s), .done(done_s)
   );
   montgomery_mult #(.N(NB)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_a(a_b), .in_b(b_b), .in_m(m_b),
      .result(res_b), .busy(busy_b), .done(done_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input bit big, input int limit, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!(big ? done_b : done_s) && cnt < limit);
   endtask

   task automatic run_small(input logic [NS-1:0] m, a, b, output int l);
      m_s = m; a_s = a; b_s = b; start_s = 1'b1;
      tick();
      start_s = 1'b0;
      wait_done(1'b0, 20, l);
      l = l + 1;
   endtask

   function automatic logic [NB+1:0] rnd();
      logic [NB+1:0] v = '0;
      for (int k = 0; k < NB / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // x*y mod m by double-and-add, independent of the Montgomery recurrence
   function automatic logic [NB-1:0] mulmod(input logic [NB-1:0] x, y, m);
      logic [NB+1:0] r = '0;
      logic [NB+1:0] xr = {2'b00, x} % {2'b00, m};
      for (int k = NB - 1; k >= 0; k--) begin
         r = r << 1;
         if (r >= {2'b00, m}) r = r - {2'b00, m};
         if (y[k]) r = r + xr;
         if (r >= {2'b00, m}) r = r - {2'b00, m};
      end
      return r[NB-1:0];
   endfunction

   initial begin
      reset = 1'b1; start_s = 1'b0; start_b = 1'b0;
      a_s = '0; b_s = '0; m_s = '0; a_b = '0; b_b = '0; m_b = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_result_s", res_s, 0);
      chk("reset_busy_s", busy_s, 0);
      chk("reset_done_s", done_s, 0);
      chk("reset_result_b", res_b, 0);
      chk("reset_busy_b", busy_b, 0);
      chk("reset_done_b", done_b, 0);

      // T1: 1*1*16^-1 mod 13 = 9
      m_s = 13; a_s = 1; b_s = 1; start_s = 1'b1;
      tick();
      start_s = 1'b0;
      chk("t1_busy", busy_s, 1);
      wait_done(1'b0, 20, n);
      chk("t1_latency", n + 1, 6);
      chk("t1_result", res_s, 9);
      tick();
      chk("t1_done_pulse", done_s, 0);
      chk("t1_result_hold", res_s, 9);

      // T2: 196 mod 15 = 1, pre-subtract C=16 forces the final subtract
      run_small(15, 14, 14, lat);
      chk("t2_latency", lat, 6);
      chk("t2_result", res_s, 1);

      // T4: reset in the 3rd LOOP cycle aborts with no done
      m_s = 15; a_s = 7; b_s = 9; start_s = 1'b1;
      tick();
      start_s = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t4_busy_after_reset", busy_s, 0);
      chk("t4_done_after_reset", done_s, 0);
      chk("t4_result_after_reset", res_s, 0);
      cnt_done = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         cnt_done += int'(done_s);
      end
      chk("t4_no_done", cnt_done, 0);
      run_small(13, 12, 12, lat);
      chk("t4_latency", lat, 6);
      chk("t4_result", res_s, 9);

      // T3: starts while busy are ignored
      m_s = 13; a_s = 0; b_s = 12; start_s = 1'b1;
      tick();
      cnt_busy = int'(busy_s);
      cnt_done = 0;
      held = 'x;
      for (int k = 1; k <= 12; k++) begin
         start_s = (k <= 3);
         m_s = 15; a_s = 14; b_s = 14;
         tick();
         cnt_busy += int'(busy_s);
         cnt_done += int'(done_s);
         if (done_s) held = res_s;
      end
      start_s = 1'b0;
      chk("t3_done_count", cnt_done, 1);
      chk("t3_busy_cycles", cnt_busy, NS + 1);
      chk("t3_result", held, 0);

      // T5: start held high gives back-to-back ops; second uses inputs present at the done cycle
      m_s = 13; a_s = 1; b_s = 1; start_s = 1'b1;
      tick();
      m_s = 11; a_s = 3; b_s = 5;
      wait_done(1'b0, 20, n);
      chk("t5_first_latency", n + 1, 6);
      chk("t5_first_result", res_s, 9);
      wait_done(1'b0, 20, n);
      start_s = 1'b0;
      chk("t5_gap", n, NS + 2);
      chk("t5_second_result", res_s, 3);

      // T6: random 1024-bit vectors, checked as result*2^N == A*B (mod M) and result < M
      for (int v = 0; v < 40; v++) begin
         m_b = rnd();
         m_b[0] = 1'b1;
         if (v % 2 == 0) m_b[NB-1] = 1'b1;
         a_b = NB'(rnd() % {2'b00, m_b});
         b_b = NB'(rnd() % {2'b00, m_b});
         start_b = 1'b1;
         tick();
         start_b = 1'b0;
         wait_done(1'b1, 1100, n);
         chk("t6_latency", n + 1, 1026);
         r2n = 1;
         for (int k = 0; k < NB; k++) r2n = mulmod(r2n, 2, m_b);
         chk("t6_range", res_b < m_b, 1);
         chk("t6_residue", mulmod(res_b, r2n, m_b), mulmod(a_b, b_b, m_b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
